// File: rtl/display_timing_if.sv
// display_timing_if
//   Bundle between the display timing generator and its painters / DVI encoder.
//   master : timing generator. It drives the coordinates, data enable, the
//            registered DVI outputs and the strobes, and it receives paint colour.
//   slave  : painter/encoder side. It is the mirror of master.
//   Signals:
//     sx, sy                  current screen coordinate (CORDW bits each)
//     de                      current coordinate lies in the active area
//     paint_r/g/b             painter colour for the current coordinate (4 bits)
//     dvi_r/g/b               registered colour, forced to 0 in blanking
//     dvi_hsync/dvi_vsync     registered sync, polarity already applied
//     dvi_de                  registered data enable
//     frame, line             registered start-of-frame / start-of-line strobes
interface display_timing_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de;
  logic [3:0]       paint_r;
  logic [3:0]       paint_g;
  logic [3:0]       paint_b;
  logic [3:0]       dvi_r;
  logic [3:0]       dvi_g;
  logic [3:0]       dvi_b;
  logic             dvi_hsync;
  logic             dvi_vsync;
  logic             dvi_de;
  logic             frame;
  logic             line;

  modport master (
    output sx, sy, de,
    output dvi_r, dvi_g, dvi_b, dvi_hsync, dvi_vsync, dvi_de,
    output frame, line,
    input  paint_r, paint_g, paint_b
  );

  modport slave (
    input  sx, sy, de,
    input  dvi_r, dvi_g, dvi_b, dvi_hsync, dvi_vsync, dvi_de,
    input  frame, line,
    output paint_r, paint_g, paint_b
  );
endinterface

// File: rtl/display_timing_gen.sv
// display_timing_gen
//   Pixel-clock timing generator and DVI output register stage (640x480 60 Hz
//   by default). It counts sx/sy for the combinational painters, takes their
//   colour back in the same cycle, and registers colour, sync and data enable
//   so that they all leave together one cycle after the coordinate.
//   Ports:
//     clk_pix    pixel clock
//     rst_pix_n  asynchronous active-low reset, released on a clk_pix edge
//     dpy        display_timing_if.master. It carries sx/sy/de out, paint_* in,
//                dvi_* out and the frame/line strobes out.
//   Configuration macro:
//     DISPLAY_TIMING_STROBE_EN  When this is defined, the frame/line strobe
//                               registers are built. Otherwise both strobes
//                               are tied to 0.
module display_timing_gen #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic clk_pix,
  input  logic rst_pix_n,
  display_timing_if.master dpy
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_FIRST = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_LAST  = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_FIRST = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_LAST  = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] sx_q, sx_d;
  logic [CORDW-1:0] sy_q, sy_d;
  logic             de;
  logic             hs_act;
  logic             vs_act;

  logic [3:0] dvi_r_q, dvi_r_d;
  logic [3:0] dvi_g_q, dvi_g_d;
  logic [3:0] dvi_b_q, dvi_b_d;
  logic       dvi_hsync_q, dvi_hsync_d;
  logic       dvi_vsync_q, dvi_vsync_d;
  logic       dvi_de_q, dvi_de_d;

  // Coordinate counters and combinational decode of the current position
  always_comb begin
    sx_d = sx_q + CORDW'(1);
    sy_d = sy_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      // The line wrap and the frame wrap land on the same edge, so
      // (H_LAST, V_LAST) steps directly to (0, 0).
      sy_d = (sy_q == V_LAST) ? '0 : sy_q + CORDW'(1);
    end
    de     = (sx_q < H_ACT) && (sy_q < V_ACT);
    hs_act = (sx_q >= HS_FIRST) && (sx_q <= HS_LAST);
    vs_act = (sy_q >= VS_FIRST) && (sy_q <= VS_LAST);
  end

  // Output stage: everything for coordinate (sx,sy) is registered on the same edge
  always_comb begin
    // Blanking is applied here only. The painters always see their own colour path.
    dvi_r_d     = de ? dpy.paint_r : 4'h0;
    dvi_g_d     = de ? dpy.paint_g : 4'h0;
    dvi_b_d     = de ? dpy.paint_b : 4'h0;
    dvi_de_d    = de;
    dvi_hsync_d = hs_act ? H_POL : ~H_POL;
    dvi_vsync_d = vs_act ? V_POL : ~V_POL;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      dvi_r_q     <= 4'h0;
      dvi_g_q     <= 4'h0;
      dvi_b_q     <= 4'h0;
      dvi_de_q    <= 1'b0;
      dvi_hsync_q <= ~H_POL;
      dvi_vsync_q <= ~V_POL;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      dvi_r_q     <= dvi_r_d;
      dvi_g_q     <= dvi_g_d;
      dvi_b_q     <= dvi_b_d;
      dvi_de_q    <= dvi_de_d;
      dvi_hsync_q <= dvi_hsync_d;
      dvi_vsync_q <= dvi_vsync_d;
    end
  end

`ifdef DISPLAY_TIMING_STROBE_EN
  logic line_q, line_d;
  logic frame_q, frame_d;

  // Strobes are registered from the same coordinate so that they line up with dvi_*
  always_comb begin
    line_d  = (sx_q == '0);
    frame_d = (sx_q == '0) && (sy_q == '0);
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign dpy.line  = line_q;
  assign dpy.frame = frame_q;
`else
  assign dpy.line  = 1'b0;
  assign dpy.frame = 1'b0;
`endif

  assign dpy.sx        = sx_q;
  assign dpy.sy        = sy_q;
  assign dpy.de        = de;
  assign dpy.dvi_r     = dvi_r_q;
  assign dpy.dvi_g     = dvi_g_q;
  assign dpy.dvi_b     = dvi_b_q;
  assign dpy.dvi_hsync = dvi_hsync_q;
  assign dpy.dvi_vsync = dvi_vsync_q;
  assign dpy.dvi_de    = dvi_de_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen
//   Drives two timing generators from one clock and one reset. The first uses
//   a reduced raster with mixed sync polarity, so that full frames fit in a
//   short run. The second uses the default 640x480 raster, and it is used for
//   reset and line timing. Each cycle, the expected output word for every
//   instance is computed from a coordinate model and the driven paint, and it
//   is pushed to a queue. The word is popped and compared after the next edge.
module tb_display_timing_gen;

  localparam int S_HR = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VR = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam bit S_HP = 1'b1, S_VP = 1'b0;
  localparam int D_HR = 640, D_HF = 16, D_HS = 96, D_HB = 48;
  localparam int D_VR = 480, D_VF = 10, D_VS = 2, D_VB = 33;
  localparam bit D_HP = 1'b0, D_VP = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pr = 4'h0, pg = 4'h0, pb = 4'h0;
  int         pmode = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  display_timing_if #(.CORDW(10)) ifs ();
  display_timing_if #(.CORDW(10)) ifd ();

  display_timing_gen #(
    .CORDW(10), .H_RES(S_HR), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_RES(S_VR), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(S_HP), .V_POL(S_VP)
  ) u_small (
    .clk_pix  (clk),
    .rst_pix_n(rst_n),
    .dpy      (ifs)
  );

  display_timing_gen u_dflt (
    .clk_pix  (clk),
    .rst_pix_n(rst_n),
    .dpy      (ifd)
  );

  assign ifs.paint_r = pr;
  assign ifs.paint_g = pg;
  assign ifs.paint_b = pb;
  assign ifd.paint_r = pr;
  assign ifd.paint_g = pg;
  assign ifd.paint_b = pb;

  // Output word: {r[3:0], g[3:0], b[3:0], hsync, vsync, de, frame, line}
  logic [16:0] obs [2];
  logic [9:0]  sxo [2];
  logic [9:0]  syo [2];
  assign obs[0] = {ifs.dvi_r, ifs.dvi_g, ifs.dvi_b, ifs.dvi_hsync, ifs.dvi_vsync,
                   ifs.dvi_de, ifs.frame, ifs.line};
  assign obs[1] = {ifd.dvi_r, ifd.dvi_g, ifd.dvi_b, ifd.dvi_hsync, ifd.dvi_vsync,
                   ifd.dvi_de, ifd.frame, ifd.line};
  assign sxo[0] = ifs.sx;
  assign syo[0] = ifs.sy;
  assign sxo[1] = ifd.sx;
  assign syo[1] = ifd.sy;

  logic [33:0] sb [$];
  int mx [2], my [2];
  int px [2], py [2];
  int ocnt;
  int de_cnt [2], hs_cnt [2], hs_first [2], vs_cnt [2];
  int fr_cnt [2], fr_first [2], fr_last [2], fr_per [2];
  int ln_cnt [2], ln_last [2], ln_per [2];
  int wrap_x [2], wrap_y [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int htot(int i);
    return (i == 0) ? S_HR + S_HF + S_HS + S_HB : D_HR + D_HF + D_HS + D_HB;
  endfunction

  function automatic int vtot(int i);
    return (i == 0) ? S_VR + S_VF + S_VS + S_VB : D_VR + D_VF + D_VS + D_VB;
  endfunction

  function automatic logic hpol(int i);
    return (i == 0) ? S_HP : D_HP;
  endfunction

  function automatic logic vpol(int i);
    return (i == 0) ? S_VP : D_VP;
  endfunction

  function automatic logic [16:0] rst_out(int i);
    return {12'h000, ~hpol(i), ~vpol(i), 3'b000};
  endfunction

  function automatic logic [16:0] exp_out(int i, int x, int y, logic [3:0] r, logic [3:0] g,
                                          logic [3:0] b);
    int hr, hf, hs, vr, vf, vs;
    logic de, ha, va, fr, ln;
    hr = (i == 0) ? S_HR : D_HR;
    hf = (i == 0) ? S_HF : D_HF;
    hs = (i == 0) ? S_HS : D_HS;
    vr = (i == 0) ? S_VR : D_VR;
    vf = (i == 0) ? S_VF : D_VF;
    vs = (i == 0) ? S_VS : D_VS;
    de = (x < hr) && (y < vr);
    ha = (x >= hr + hf) && (x < hr + hf + hs);
    va = (y >= vr + vf) && (y < vr + vf + vs);
`ifdef DISPLAY_TIMING_STROBE_EN
    ln = (x == 0);
    fr = (x == 0) && (y == 0);
`else
    ln = 1'b0;
    fr = 1'b0;
`endif
    if (!de) begin
      r = 4'h0;
      g = 4'h0;
      b = 4'h0;
    end
    return {r, g, b, ha ? hpol(i) : ~hpol(i), va ? vpol(i) : ~vpol(i), de, fr, ln};
  endfunction

  task automatic clear_stats();
    ocnt = 0;
    for (int i = 0; i < 2; i++) begin
      de_cnt[i] = 0; hs_cnt[i] = 0; hs_first[i] = -1; vs_cnt[i] = 0;
      fr_cnt[i] = 0; fr_first[i] = -1; fr_last[i] = 0; fr_per[i] = 0;
      ln_cnt[i] = 0; ln_last[i] = 0; ln_per[i] = 0;
      wrap_x[i] = -1; wrap_y[i] = -1; px[i] = -1; py[i] = -1;
    end
  endtask

  task automatic update_stats(input int i, input logic [16:0] got);
    if (got[2]) de_cnt[i]++;
    if (got[4] == hpol(i)) begin
      if (hs_cnt[i] == 0) hs_first[i] = ocnt;
      hs_cnt[i]++;
    end
    if (got[3] == vpol(i)) vs_cnt[i]++;
    if (got[1]) begin
      if (fr_cnt[i] == 0) fr_first[i] = ocnt;
      else fr_per[i] = ocnt - fr_last[i];
      fr_last[i] = ocnt;
      fr_cnt[i]++;
    end
    if (got[0]) begin
      if (ln_cnt[i] > 0) ln_per[i] = ocnt - ln_last[i];
      ln_last[i] = ocnt;
      ln_cnt[i]++;
    end
  endtask

  // One pixel clock: drive paint, check the coordinate, push the expected
  // output, then pop and compare it after the edge.
  task automatic step();
    logic [33:0] e;
    string t;
    @(negedge clk);
    if (pmode == 0) begin
      pr = 4'hF; pg = 4'hC; pb = 4'h0;
    end else begin
      pr = 4'($urandom_range(15));
      pg = 4'($urandom_range(15));
      pb = 4'($urandom_range(15));
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      t = (i == 0) ? "s" : "d";
      if (rst_n) begin
        check({"sx_", t}, 32'(sxo[i]), 32'(mx[i]));
        check({"sy_", t}, 32'(syo[i]), 32'(my[i]));
        if (px[i] >= 0 && sxo[i] == 10'd0 && syo[i] == 10'd0) begin
          wrap_x[i] = px[i];
          wrap_y[i] = py[i];
        end
        px[i] = int'(sxo[i]);
        py[i] = int'(syo[i]);
      end else begin
        check({"rst_sx_", t}, 32'(sxo[i]), 32'd0);
        check({"rst_sy_", t}, 32'(syo[i]), 32'd0);
        check({"rst_out_", t}, 32'(obs[i]), 32'(rst_out(i)));
        px[i] = -1;
      end
    end
    if (rst_n) sb.push_back({exp_out(1, mx[1], my[1], pr, pg, pb),
                             exp_out(0, mx[0], my[0], pr, pg, pb)});
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_s", 32'(obs[0]), 32'(e[16:0]));
        check("out_d", 32'(obs[1]), 32'(e[33:17]));
        for (int i = 0; i < 2; i++) begin
          update_stats(i, obs[i]);
          mx[i]++;
          if (mx[i] == htot(i)) begin
            mx[i] = 0;
            my[i]++;
            if (my[i] == vtot(i)) my[i] = 0;
          end
        end
        ocnt++;
      end
    end else begin
      check("rst_out_s_edge", 32'(obs[0]), 32'(rst_out(0)));
      check("rst_out_d_edge", 32'(obs[1]), 32'(rst_out(1)));
    end
  endtask

  // Called just after a posedge. Reset is released between edges, so the next
  // edge is the first active one.
  task automatic release_reset();
    #2;
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    clear_stats();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0;
      my[i] = 0;
    end

    // Reset held for 5 cycles.
    rst_n = 1'b0;
    repeat (5) step();
    release_reset();

    // One full default line with constant F/C/0 paint.
    pmode = 0;
    clear_stats();
    step();
    check("de_after_release_d", 32'(obs[1][2]), 32'd1);
    repeat (799) step();
    check("line_de_cnt_d", de_cnt[1], 640);
    check("line_hs_cnt_d", hs_cnt[1], 96);
    // x=656, which is the 657th cycle of the line counting the first dvi_de as 1
    check("line_hs_first_d", hs_first[1], 656);
    check("line_vs_cnt_d", vs_cnt[1], 0);
    check("line_wrap_sx_d", 32'(sxo[1]), 32'd0);
    check("line_wrap_sy_d", 32'(syo[1]), 32'd1);
`ifdef DISPLAY_TIMING_STROBE_EN
    check("line_strobe_cnt_d", ln_cnt[1], 1);
    check("frame_strobe_cnt_d", fr_cnt[1], 1);
`else
    check("line_strobe_cnt_d", ln_cnt[1], 0);
    check("frame_strobe_cnt_d", fr_cnt[1], 0);
`endif

    // Two full reduced frames with random paint, starting at (0,0).
    pmode = 1;
    guard = 0;
    while (!(mx[0] == 0 && my[0] == 0) && guard < 1000) begin
      step();
      guard++;
    end
    check("align_frame_s", 32'(guard < 1000), 32'd1);
    clear_stats();
    repeat (2 * 25 * 13) step();
    check("frame_de_cnt_s", de_cnt[0], 2 * S_HR * S_VR);
    check("frame_hs_cnt_s", hs_cnt[0], 2 * 13 * S_HS);
    check("frame_vs_cnt_s", vs_cnt[0], 2 * S_VS * 25);
    check("frame_wrap_x_s", wrap_x[0], 24);
    check("frame_wrap_y_s", wrap_y[0], 12);
`ifdef DISPLAY_TIMING_STROBE_EN
    check("frame_cnt_s", fr_cnt[0], 2);
    check("frame_first_s", fr_first[0], 0);
    check("frame_per_s", fr_per[0], 325);
    check("line_cnt_s", ln_cnt[0], 26);
    check("line_per_s", ln_per[0], 25);
`else
    check("frame_cnt_s", fr_cnt[0], 0);
    check("line_cnt_s", ln_cnt[0], 0);
`endif

    // Asynchronous reset in the middle of a reduced frame.
    guard = 0;
    while (!(mx[0] == 10 && my[0] == 5) && guard < 1000) begin
      step();
      guard++;
    end
    check("align_mid_s", 32'(guard < 1000), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst_sx", 32'(sxo[i]), 32'd0);
      check("async_rst_sy", 32'(syo[i]), 32'd0);
      check("async_rst_out", 32'(obs[i]), 32'(rst_out(i)));
    end
    repeat (3) step();
    release_reset();
    clear_stats();
    repeat (400) step();
    check("restart_de_cnt_s", de_cnt[0], S_HR * S_VR + (400 - 325 >= 0 ? 3 * S_HR : 0));
`ifdef DISPLAY_TIMING_STROBE_EN
    check("restart_frame_first_s", fr_first[0], 0);
    check("restart_frame_cnt_s", fr_cnt[0], 2);
`else
    check("restart_frame_cnt_s", fr_cnt[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
